scoreboard_mc: RTL and testbench
================================

// Module: scoreboard_mc
// PURPOSE
//  Parametrised multi-issue register scoreboard for the compute unit, successor to the 2-slot busy-bit scoreboard.
//  Tracks outstanding writes per register with saturating pending counters (multiple in-flight writes to one register).
//  Classes tracked: scalar, FP and vector. Generates per-lane issue stalls for RAW, counter-full and in-bundle hazards.
//  Sits between decode/issue and the RR stage; WB and flush paths return credits.
// PARAMETERS
//  ISSUE_W     2  issue lanes per cycle (lane 0 oldest)
//  WB_PORTS    7  writeback ports, each class-tagged
//  FLUSH_PORTS 3  per-instruction flush-return ports (RR0/RR1/EX1)
//  CNT_W       2  pending-counter width; CMAX = 2**CNT_W-1 outstanding writes per register
// PORTS
//  clk            in  1             clock, all state on posedge
//  rst            in  1             asynchronous active-high reset
//  iss_valid      in  ISSUE_W       lane holds an instruction
//  iss_rs1_valid  in  ISSUE_W       rs1 used;  iss_rs2_valid same for rs2
//  iss_rs1_class  in  2*ISSUE_W     00 scalar, 01 FP, 1x vector; iss_rs2_class, iss_rd_class same coding
//  iss_rs1/rs2/rd in  5*ISSUE_W     register indices
//  iss_rs1_fwd    in  ISSUE_W       bypass available for rs1; iss_rs2_fwd same for rs2 (ignored for FP)
//  iss_rd_valid   in  ISSUE_W       lane writes rd
//  accept         in  ISSUE_W       lane actually enters pipe; must imply !stall of that lane
//  stall          out ISSUE_W       lane must hold
//  wb_valid       in  WB_PORTS      writeback retires one pending write
//  wb_class       in  2*WB_PORTS    class of each writeback
//  wb_rd          in  5*WB_PORTS    register of each writeback
//  fl_valid       in  FLUSH_PORTS   killed instruction returns credit
//  fl_class       in  2*FLUSH_PORTS class of killed instruction
//  fl_rd          in  5*FLUSH_PORTS register of killed instruction
//  flush_all      in  1             clear all counters
//  busy_any       out 1             any counter nonzero (drain/fence)
//  err_ovf        out 1             sticky: counter increment clamped at CMAX
//  err_unf        out 1             sticky: decrement below 0
// BEHAVIOUR
//  - State: cnt[class][reg], 3x32 counters of CNT_W bits. Scalar x0 is never tracked; its cnt stays 0. FP0/V0 are normal registers.
//  - Reset (async): all cnt=0, err_ovf=err_unf=0. stall=0 while no lane is valid. busy_any=0.
//  - hits[c][r]: number of wb ports matching class c and register r this cycle.
//  - Source busy: cnt != 0 and hits < cnt and !fwd. Same-cycle WB relaxes the stall only if it retires every pending write.
//  - Dest stall: cnt + older-lane accepts to the same class/reg + 1 > CMAX + hits.
//  - In-bundle RAW: lane j stalls if an older non-stalled valid lane i writes a reg that j reads (same class, not x0).
//  - In-bundle WAW: allowed; both writes count.
//  - In-order: stall[j] = 1 if any older valid lane stalls.
//  - stall[j] = iss_valid[j] & (src busy | dest full | RAW | older stall). It is combinational, with no dependence on accept.
//  - Update each cycle: next = cnt + inc - hits - flush_hits.
//    - inc counts accept & rd_valid lanes per reg.
//    - flush_hits counts matching fl ports.
//    - Clamp to [0, CMAX]. Clamp at CMAX sets err_ovf; clamp at 0 sets err_unf.
//  - flush_all takes priority over all updates in the same cycle: every cnt clears to 0 next cycle. err flags are cleared only by rst.
//  - Combinational latency: the stall response is 0-cycle. A set takes effect on the next cycle's stall.
//  - busy_any is registered, the OR of all cnt after update.
// CONFIGURATION
//  SB_STALL_STATS_EN defined: adds ports
//    - stat_clr  in  1
//    - stat_raw  out 32*ISSUE_W, per-lane RAW-stall cycle counts
//    - stat_full out 32*ISSUE_W, per-lane dest-full stall cycle counts
//  The counters saturate at 2**32-1. They are cleared by rst or stat_clr; clear wins over increment.
//  Undefined: these ports and counters are absent. Stall behaviour is identical either way.
// TESTING
//  1. Issue x5 write lane0 (accept), next cycle lane0 reads x5 -> stall0=1. wb x5 same cycle -> stall0=0, cnt=0.
//  2. Three accepted writes to f3 (CNT_W=2): a fourth write to f3 -> stall=1. One wb f3 -> stall=0 in that cycle.
//  3. Lane0 writes v2, lane1 reads v2, both valid -> stall={1,0}. Lane1 writes v2 only -> stall=0, cnt=2 after accept.
//  4. Lane0 stalled on busy x7, lane1 independent -> stall1=1 (in-order). x0 writes never set cnt or stall.
//  5. cnt[s][4]=2. Same cycle: wb x4, flush x4, accept write x4 -> cnt=1. flush_all with accept -> all 0, busy_any=0.
//  6. wb x9 with cnt=0 -> err_unf=1, cnt stays 0. Assert rst mid-stall -> stall/err/cnt=0 immediately, async.

Source files
------------

// File: rtl/scoreboard_mc.sv
// -----------------------------------------------------------------------------
// scoreboard_mc
//   Multi-issue register scoreboard. Each of the 3x32 registers (scalar, FP,
//   vector) carries a saturating pending-write counter. Issue lanes are stalled
//   combinationally for source RAW, destination counter-full and in-bundle RAW
//   hazards. Issue is in order: a stalled lane also holds every younger lane.
//   Writeback and per-instruction flush ports return credits. flush_all clears
//   all counters.
//
// Optional feature: define SB_STALL_STATS_EN to add per-lane stall statistics
//   counters (stat_clr, stat_raw, stat_full). Stall behaviour does not change.
//
// Ports
//   clk, rst              clock and asynchronous active-high reset
//   iss_*                 per-lane issue bundle (lane 0 oldest), class coding:
//                         00 scalar, 01 FP, 1x vector
//   accept                lane enters the pipe (only legal when not stalled)
//   stall                 lane must hold (combinational)
//   wb_valid/class/rd     writeback ports, each retires one pending write
//   fl_valid/class/rd     flushed instructions return their credit
//   flush_all             clear every counter
//   busy_any              registered OR of all counters
//   err_ovf, err_unf      sticky clamp flags, cleared only by rst
// -----------------------------------------------------------------------------
module scoreboard_mc #(
   parameter int ISSUE_W     = 2,
   parameter int WB_PORTS    = 7,
   parameter int FLUSH_PORTS = 3,
   parameter int CNT_W       = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ISSUE_W-1:0]         iss_valid,
   input  logic [ISSUE_W-1:0]         iss_rs1_valid,
   input  logic [ISSUE_W-1:0]         iss_rs2_valid,
   input  logic [2*ISSUE_W-1:0]       iss_rs1_class,
   input  logic [2*ISSUE_W-1:0]       iss_rs2_class,
   input  logic [2*ISSUE_W-1:0]       iss_rd_class,
   input  logic [5*ISSUE_W-1:0]       iss_rs1,
   input  logic [5*ISSUE_W-1:0]       iss_rs2,
   input  logic [5*ISSUE_W-1:0]       iss_rd,
   input  logic [ISSUE_W-1:0]         iss_rs1_fwd,
   input  logic [ISSUE_W-1:0]         iss_rs2_fwd,
   input  logic [ISSUE_W-1:0]         iss_rd_valid,
   input  logic [ISSUE_W-1:0]         accept,
   output logic [ISSUE_W-1:0]         stall,
   input  logic [WB_PORTS-1:0]        wb_valid,
   input  logic [2*WB_PORTS-1:0]      wb_class,
   input  logic [5*WB_PORTS-1:0]      wb_rd,
   input  logic [FLUSH_PORTS-1:0]     fl_valid,
   input  logic [2*FLUSH_PORTS-1:0]   fl_class,
   input  logic [5*FLUSH_PORTS-1:0]   fl_rd,
   input  logic                       flush_all,
   output logic                       busy_any,
   output logic                       err_ovf,
   output logic                       err_unf
`ifdef SB_STALL_STATS_EN
   ,
   input  logic                       stat_clr,
   output logic [32*ISSUE_W-1:0]      stat_raw,
   output logic [32*ISSUE_W-1:0]      stat_full
`endif
);

   localparam int NCLS = 3;
   localparam int NREG = 32;
   localparam int CMAX = (1 << CNT_W) - 1;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [7:0]       acc_t;   // per-cycle tallies, wide enough for any port count used here

   // Class code to counter-bank index: 00 scalar, 01 FP, 1x vector.
   function automatic logic [1:0] cls_idx(input logic [1:0] c);
      return c[1] ? 2'd2 : {1'b0, c[0]};
   endfunction

   // Scalar x0 is hardwired zero and never tracked.
   function automatic logic tracked(input logic [1:0] c, input logic [4:0] r);
      return !(c == 2'd0 && r == 5'd0);
   endfunction

   cnt_t cnt     [NCLS][NREG];
   cnt_t cnt_nxt [NCLS][NREG];
   acc_t hits    [NCLS][NREG];
   acc_t fhits   [NCLS][NREG];
   acc_t inc     [NCLS][NREG];
   logic ovf_now, unf_now, any_nxt;
   logic [ISSUE_W-1:0] lane_raw, lane_full;

   // Per-register tallies of this cycle's writebacks, flush returns and accepted writes.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      for (int c = 0; c < NCLS; c++)
         for (int r = 0; r < NREG; r++) begin
            hits[c][r]  = '0;
            fhits[c][r] = '0;
            inc[c][r]   = '0;
         end
      for (int p = 0; p < WB_PORTS; p++)
         if (wb_valid[p])
            hits[cls_idx(wb_class[2*p +: 2])][wb_rd[5*p +: 5]] += acc_t'(1);
      for (int p = 0; p < FLUSH_PORTS; p++)
         if (fl_valid[p])
            fhits[cls_idx(fl_class[2*p +: 2])][fl_rd[5*p +: 5]] += acc_t'(1);
      for (int l = 0; l < ISSUE_W; l++)
         if (accept[l] && iss_rd_valid[l])
            inc[cls_idx(iss_rd_class[2*l +: 2])][iss_rd[5*l +: 5]] += acc_t'(1);
   end

   // Stall generation. Independent of accept, so accept can be derived from stall.
   always_comb begin
      logic       older_stall, raw, full, sv, sf;
      logic [1:0] sc, dc;
      logic [4:0] sr, dr;
      acc_t       older_wr;
      stall       = '0;
      lane_raw    = '0;
      lane_full   = '0;
      older_stall = 1'b0;
      for (int j = 0; j < ISSUE_W; j++) begin
         raw = 1'b0;
         full = 1'b0;
         for (int k = 0; k < 2; k++) begin
            sv = (k == 0) ? iss_rs1_valid[j] : iss_rs2_valid[j];
            sc = cls_idx((k == 0) ? iss_rs1_class[2*j +: 2] : iss_rs2_class[2*j +: 2]);
            sr = (k == 0) ? iss_rs1[5*j +: 5] : iss_rs2[5*j +: 5];
            // FP results have no bypass path, so fwd is ignored for FP sources.
            sf = ((k == 0) ? iss_rs1_fwd[j] : iss_rs2_fwd[j]) && (sc != 2'd1);
            if (sv) begin
               // A same-cycle writeback only helps if it retires every pending write.
               if (cnt[sc][sr] != '0 && hits[sc][sr] < acc_t'(cnt[sc][sr]) && !sf)
                  raw = 1'b1;
               for (int i = 0; i < j; i++)
                  if (iss_valid[i] && !stall[i] && iss_rd_valid[i] && tracked(sc, sr) &&
                      cls_idx(iss_rd_class[2*i +: 2]) == sc && iss_rd[5*i +: 5] == sr)
                     raw = 1'b1;
            end
         end
         dc = cls_idx(iss_rd_class[2*j +: 2]);
         dr = iss_rd[5*j +: 5];
         older_wr = '0;
         for (int i = 0; i < j; i++)
            if (iss_valid[i] && iss_rd_valid[i] &&
                cls_idx(iss_rd_class[2*i +: 2]) == dc && iss_rd[5*i +: 5] == dr)
               older_wr += acc_t'(1);
         if (iss_rd_valid[j] && tracked(dc, dr) &&
             acc_t'(cnt[dc][dr]) + older_wr + acc_t'(1) > acc_t'(CMAX) + hits[dc][dr])
            full = 1'b1;
         lane_raw[j]  = iss_valid[j] & raw;
         lane_full[j] = iss_valid[j] & full;
         stall[j]     = iss_valid[j] & (raw | full | older_stall);
         older_stall  = older_stall | stall[j];
      end
   end

   // Counter update with clamping to [0, CMAX].
   always_comb begin
      int s;
      ovf_now = 1'b0;
      unf_now = 1'b0;
      any_nxt = 1'b0;
      for (int c = 0; c < NCLS; c++)
         for (int r = 0; r < NREG; r++) begin
            s = int'(cnt[c][r]) + int'(inc[c][r]) - int'(hits[c][r]) - int'(fhits[c][r]);
            cnt_nxt[c][r] = '0;
            if (!(c == 0 && r == 0)) begin
               if (s > CMAX) begin
                  cnt_nxt[c][r] = cnt_t'(CMAX);
                  ovf_now = 1'b1;
               end else if (s < 0) begin
                  unf_now = 1'b1;
               end else begin
                  cnt_nxt[c][r] = cnt_t'(s);
               end
            end
            any_nxt = any_nxt | (cnt_nxt[c][r] != '0);
         end
   end

   // NOTE: the counter array is architectural state read by stall logic, so every entry is reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NCLS; c++)
            for (int r = 0; r < NREG; r++)
               cnt[c][r] <= '0;
         busy_any <= 1'b0;
         err_ovf  <= 1'b0;
         err_unf  <= 1'b0;
      end else if (flush_all) begin
         for (int c = 0; c < NCLS; c++)
            for (int r = 0; r < NREG; r++)
               cnt[c][r] <= '0;
         busy_any <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         cnt      <= cnt_nxt;
         busy_any <= any_nxt;
         err_ovf  <= err_ovf | ovf_now;
         err_unf  <= err_unf | unf_now;
      end
   end

`ifdef SB_STALL_STATS_EN
   logic [31:0] raw_q  [ISSUE_W];
   logic [31:0] full_q [ISSUE_W];

   // Saturating per-lane stall-cycle counters; clear wins over increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < ISSUE_W; j++) begin
            raw_q[j]  <= '0;
            full_q[j] <= '0;
         end
      end else begin
         for (int j = 0; j < ISSUE_W; j++) begin
            if (stat_clr) begin
               raw_q[j]  <= '0;
               full_q[j] <= '0;
            end else begin
               if (lane_raw[j] && raw_q[j] != '1)
                  raw_q[j] <= raw_q[j] + 32'd1;
               if (lane_full[j] && full_q[j] != '1)
                  full_q[j] <= full_q[j] + 32'd1;
            end
         end
      end
   end

   always_comb begin
      stat_raw  = '0;
      stat_full = '0;
      for (int j = 0; j < ISSUE_W; j++) begin
         stat_raw[32*j +: 32]  = raw_q[j];
         stat_full[32*j +: 32] = full_q[j];
      end
   end
`else
   logic unused_stats;
   assign unused_stats = ^{lane_raw, lane_full};
`endif

endmodule

// File: tb/tb_scoreboard_mc.sv
// -----------------------------------------------------------------------------
// tb_scoreboard_mc
//   Directed bench for scoreboard_mc at default parameters. A table of
//   single-cycle vectors (lane sources/dest, accept, one writeback port) with
//   expected stall and busy_any, followed by hand-written multi-cycle sequences
//   for flush returns, flush_all, clamping, forwarding and async reset.
// -----------------------------------------------------------------------------
module tb_scoreboard_mc;

   localparam int IW = 2;
   localparam int WB = 7;
   localparam int FL = 3;
   localparam logic [1:0] S = 2'b00;
   localparam logic [1:0] F = 2'b01;
   localparam logic [1:0] V = 2'b10;

   logic              clk = 1'b0;
   logic              rst;
   logic [IW-1:0]     iss_valid, iss_rs1_valid, iss_rs2_valid;
   logic [2*IW-1:0]   iss_rs1_class, iss_rs2_class, iss_rd_class;
   logic [5*IW-1:0]   iss_rs1, iss_rs2, iss_rd;
   logic [IW-1:0]     iss_rs1_fwd, iss_rs2_fwd, iss_rd_valid, accept, stall;
   logic [WB-1:0]     wb_valid;
   logic [2*WB-1:0]   wb_class;
   logic [5*WB-1:0]   wb_rd;
   logic [FL-1:0]     fl_valid;
   logic [2*FL-1:0]   fl_class;
   logic [5*FL-1:0]   fl_rd;
   logic              flush_all, busy_any, err_ovf, err_unf;

   int n_pass  = 0;
   int n_total = 0;

   scoreboard_mc dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_rs1_valid(iss_rs1_valid), .iss_rs2_valid(iss_rs2_valid),
      .iss_rs1_class(iss_rs1_class), .iss_rs2_class(iss_rs2_class), .iss_rd_class(iss_rd_class),
      .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
      .iss_rs1_fwd(iss_rs1_fwd), .iss_rs2_fwd(iss_rs2_fwd), .iss_rd_valid(iss_rd_valid),
      .accept(accept), .stall(stall),
      .wb_valid(wb_valid), .wb_class(wb_class), .wb_rd(wb_rd),
      .fl_valid(fl_valid), .fl_class(fl_class), .fl_rd(fl_rd),
      .flush_all(flush_all), .busy_any(busy_any), .err_ovf(err_ovf), .err_unf(err_unf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] v;
      logic [1:0] r1v;
      logic [3:0] r1c;
      logic [9:0] r1;
      logic [1:0] rdv;
      logic [3:0] rdc;
      logic [9:0] rd;
      logic [1:0] acc;
      logic       wbv;
      logic [1:0] wbc;
      logic [4:0] wbr;
      logic [1:0] exp_stall;
      logic       exp_busy;
      string      name;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic clr_in();
      iss_valid = '0; iss_rs1_valid = '0; iss_rs2_valid = '0;
      iss_rs1_class = '0; iss_rs2_class = '0; iss_rd_class = '0;
      iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
      iss_rs1_fwd = '0; iss_rs2_fwd = '0; iss_rd_valid = '0; accept = '0;
      wb_valid = '0; wb_class = '0; wb_rd = '0;
      fl_valid = '0; fl_class = '0; fl_rd = '0;
      flush_all = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int l, input logic [1:0] c, input logic [4:0] r, input logic acc);
      iss_valid[l] = 1'b1; iss_rd_valid[l] = 1'b1;
      iss_rd_class[2*l +: 2] = c; iss_rd[5*l +: 5] = r; accept[l] = acc;
   endtask

   task automatic set_rs1(input int l, input logic [1:0] c, input logic [4:0] r, input logic fwd);
      iss_valid[l] = 1'b1; iss_rs1_valid[l] = 1'b1;
      iss_rs1_class[2*l +: 2] = c; iss_rs1[5*l +: 5] = r; iss_rs1_fwd[l] = fwd;
   endtask

   task automatic set_rs2(input int l, input logic [1:0] c, input logic [4:0] r, input logic fwd);
      iss_valid[l] = 1'b1; iss_rs2_valid[l] = 1'b1;
      iss_rs2_class[2*l +: 2] = c; iss_rs2[5*l +: 5] = r; iss_rs2_fwd[l] = fwd;
   endtask

   task automatic set_wb(input int p, input logic [1:0] c, input logic [4:0] r);
      wb_valid[p] = 1'b1; wb_class[2*p +: 2] = c; wb_rd[5*p +: 5] = r;
   endtask

   task automatic set_fl(input int p, input logic [1:0] c, input logic [4:0] r);
      fl_valid[p] = 1'b1; fl_class[2*p +: 2] = c; fl_rd[5*p +: 5] = r;
   endtask

   initial begin
      //          v      r1v    r1c    r1                rdv    rdc    rd                acc    wbv   wbc wbr    stall  busy  name
      vecs[0]  = '{2'b00, 2'b00, {S,S}, {5'd0,5'd0},  2'b00, {S,S}, {5'd0,5'd0},  2'b00, 1'b0, S, 5'd0, 2'b00, 1'b0, "idle"};
      vecs[1]  = '{2'b01, 2'b00, {S,S}, {5'd0,5'd0},  2'b01, {S,S}, {5'd0,5'd5},  2'b01, 1'b0, S, 5'd0, 2'b00, 1'b1, "wr_x5"};
      vecs[2]  = '{2'b01, 2'b01, {S,S}, {5'd0,5'd5},  2'b00, {S,S}, {5'd0,5'd0},  2'b00, 1'b0, S, 5'd0, 2'b01, 1'b1, "raw_x5"};
      vecs[3]  = '{2'b01, 2'b01, {S,S}, {5'd0,5'd5},  2'b00, {S,S}, {5'd0,5'd0},  2'b01, 1'b1, S, 5'd5, 2'b00, 1'b0, "raw_x5_wb"};
      vecs[4]  = '{2'b01, 2'b00, {S,S}, {5'd0,5'd0},  2'b01, {S,F}, {5'd0,5'd3},  2'b01, 1'b0, S, 5'd0, 2'b00, 1'b1, "f3_w1"};
      vecs[5]  = '{2'b11, 2'b00, {S,S}, {5'd0,5'd0},  2'b11, {F,F}, {5'd3,5'd3},  2'b11, 1'b0, S, 5'd0, 2'b00, 1'b1, "f3_w23"};
      vecs[6]  = '{2'b01, 2'b00, {S,S}, {5'd0,5'd0},  2'b01, {S,F}, {5'd0,5'd3},  2'b00, 1'b0, S, 5'd0, 2'b01, 1'b1, "f3_full"};
      vecs[7]  = '{2'b01, 2'b00, {S,S}, {5'd0,5'd0},  2'b01, {S,F}, {5'd0,5'd3},  2'b01, 1'b1, F, 5'd3, 2'b00, 1'b1, "f3_full_wb"};
      vecs[8]  = '{2'b00, 2'b00, {S,S}, {5'd0,5'd0},  2'b00, {S,S}, {5'd0,5'd0},  2'b00, 1'b1, F, 5'd3, 2'b00, 1'b1, "f3_drain2"};
      vecs[9]  = '{2'b00, 2'b00, {S,S}, {5'd0,5'd0},  2'b00, {S,S}, {5'd0,5'd0},  2'b00, 1'b1, F, 5'd3, 2'b00, 1'b1, "f3_drain1"};
      vecs[10] = '{2'b00, 2'b00, {S,S}, {5'd0,5'd0},  2'b00, {S,S}, {5'd0,5'd0},  2'b00, 1'b1, F, 5'd3, 2'b00, 1'b0, "f3_drain0"};
      vecs[11] = '{2'b11, 2'b10, {V,S}, {5'd2,5'd0},  2'b01, {S,V}, {5'd0,5'd2},  2'b00, 1'b0, S, 5'd0, 2'b10, 1'b0, "v2_bundle_raw"};
      vecs[12] = '{2'b11, 2'b00, {S,S}, {5'd0,5'd0},  2'b11, {V,V}, {5'd2,5'd2},  2'b11, 1'b0, S, 5'd0, 2'b00, 1'b1, "v2_waw"};
      vecs[13] = '{2'b01, 2'b00, {S,S}, {5'd0,5'd0},  2'b01, {S,S}, {5'd0,5'd7},  2'b01, 1'b0, S, 5'd0, 2'b00, 1'b1, "x7_set"};
      vecs[14] = '{2'b11, 2'b11, {S,S}, {5'd10,5'd7}, 2'b00, {S,S}, {5'd0,5'd0},  2'b00, 1'b0, S, 5'd0, 2'b11, 1'b1, "in_order"};
      vecs[15] = '{2'b11, 2'b10, {S,S}, {5'd0,5'd0},  2'b01, {S,S}, {5'd0,5'd0},  2'b11, 1'b0, S, 5'd0, 2'b00, 1'b1, "x0_write"};
      vecs[16] = '{2'b01, 2'b01, {S,S}, {5'd0,5'd0},  2'b00, {S,S}, {5'd0,5'd0},  2'b01, 1'b0, S, 5'd0, 2'b00, 1'b1, "x0_read"};

      rst = 1'b1;
      clr_in();
      #12;
      check("rst_stall", stall, 2'b00);
      check("rst_busy", busy_any, 1'b0);
      check("rst_err_ovf", err_ovf, 1'b0);
      check("rst_err_unf", err_unf, 1'b0);
      #1 rst = 1'b0;
      tick();

      for (int i = 0; i < 17; i++) begin
         clr_in();
         iss_valid = vecs[i].v;
         iss_rs1_valid = vecs[i].r1v; iss_rs1_class = vecs[i].r1c; iss_rs1 = vecs[i].r1;
         iss_rd_valid = vecs[i].rdv; iss_rd_class = vecs[i].rdc; iss_rd = vecs[i].rd;
         accept = vecs[i].acc;
         if (vecs[i].wbv) set_wb(0, vecs[i].wbc, vecs[i].wbr);
         #1 check({vecs[i].name, "_stall"}, stall, vecs[i].exp_stall);
         tick();
         check({vecs[i].name, "_busy"}, busy_any, vecs[i].exp_busy);
      end

      // x4 to 2, then wb + flush + accepted write in one cycle leaves 1.
      clr_in(); set_rd(0, S, 5'd4, 1'b1); set_rd(1, S, 5'd4, 1'b1);
      #1 check("x4_fill_stall", stall, 2'b00);
      tick();
      clr_in(); set_rd(0, S, 5'd4, 1'b1); set_wb(0, S, 5'd4); set_fl(0, S, 5'd4);
      #1 check("x4_mixed_stall", stall, 2'b00);
      tick();
      clr_in(); set_rs1(0, S, 5'd4, 1'b0);
      #1 check("x4_cnt_nonzero", stall, 2'b01);
      set_wb(0, S, 5'd4);
      #1 check("x4_cnt_le1", stall, 2'b00);
      clr_in();
      tick();

      // flush_all beats a simultaneous accepted write.
      set_rd(0, S, 5'd4, 1'b1); flush_all = 1'b1;
      #1 check("flush_all_stall", stall, 2'b00);
      tick();
      check("flush_all_busy", busy_any, 1'b0);
      clr_in(); set_rs1(0, S, 5'd4, 1'b0);
      #1 check("flush_all_x4", stall, 2'b00);
      clr_in(); set_rs1(0, V, 5'd2, 1'b0);
      #1 check("flush_all_v2", stall, 2'b00);
      clr_in();

      // Underflow: x0 is untracked, x9 is not.
      set_wb(0, S, 5'd0);
      tick();
      check("wb_x0_no_unf", err_unf, 1'b0);
      clr_in(); set_wb(0, S, 5'd9);
      tick();
      check("wb_x9_unf", err_unf, 1'b1);
      check("wb_x9_no_ovf", err_ovf, 1'b0);
      check("wb_x9_busy", busy_any, 1'b0);
      clr_in(); set_rs1(0, S, 5'd9, 1'b0);
      #1 check("x9_stays_0", stall, 2'b00);

      // Forwarding: honoured for scalar, ignored for FP; rs2 path.
      clr_in(); set_rd(0, S, 5'd12, 1'b1);
      tick();
      clr_in(); set_rs1(0, S, 5'd12, 1'b1);
      #1 check("x12_fwd", stall, 2'b00);
      clr_in(); set_rs2(0, S, 5'd12, 1'b0);
      #1 check("x12_rs2_busy", stall, 2'b01);
      clr_in(); set_rd(0, F, 5'd12, 1'b1);
      tick();
      clr_in(); set_rs1(0, F, 5'd12, 1'b1);
      #1 check("f12_fwd_ignored", stall, 2'b01);

      // Overflow: an accept forced past CMAX clamps at 3 and sets err_ovf.
      clr_in(); set_rd(0, F, 5'd5, 1'b1); set_rd(1, F, 5'd5, 1'b1);
      tick();
      clr_in(); set_rd(0, F, 5'd5, 1'b1);
      tick();
      clr_in(); set_rd(0, F, 5'd5, 1'b0);
      #1 check("f5_full", stall, 2'b01);
      accept[0] = 1'b1;
      tick();
      check("f5_err_ovf", err_ovf, 1'b1);
      clr_in(); set_rs1(0, F, 5'd5, 1'b0); set_wb(0, F, 5'd5); set_wb(1, F, 5'd5);
      #1 check("f5_clamp_2wb", stall, 2'b01);
      set_wb(2, F, 5'd5);
      #1 check("f5_clamp_3wb", stall, 2'b00);
      clr_in();

      // Asynchronous reset in the middle of a stall.
      set_rd(0, S, 5'd7, 1'b1);
      tick();
      clr_in(); set_rs1(0, S, 5'd7, 1'b0);
      #1 check("x7_pre_rst", stall, 2'b01);
      #2 rst = 1'b1;
      #1;
      check("async_rst_stall", stall, 2'b00);
      check("async_rst_busy", busy_any, 1'b0);
      check("async_rst_ovf", err_ovf, 1'b0);
      check("async_rst_unf", err_unf, 1'b0);
      #2 rst = 1'b0;
      #1 check("post_rst_x7", stall, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
